sensor_fifo_arbiter: RTL and testbench
======================================

// Module: sensor_fifo_arbiter
// PURPOSE
//  Round-robin burst arbiter sharing one streaming_fifo write port among N_CH sensor channels.
//  - Each channel presents valid/data; the arbiter grants one owner at a time for up to BURST_LEN beats.
//  - Each accepted beat is written to the FIFO tagged with the owner's channel id.
//  - Sits between the sensor front-ends and streaming_fifo (wr_en/wr_data/full) in sensor_top.
// PARAMETERS
//  N_CH        4   number of requesting channels (2..2**ID_W)
//  DATA_WIDTH  8   payload bits per channel beat
//  ID_W        2   channel-id tag width; FIFO word = ID_W+DATA_WIDTH
//  BURST_LEN   4   max beats per grant (>=1); beat counter width = $clog2(BURST_LEN)+1
// PORTS
//  clk           in   1                clock, all logic on posedge
//  rst           in   1                asynchronous reset, active-high
//  arb_en        in   1                1 = new grants allowed; 0 = no new grant, current burst completes
//  req_valid     in   N_CH             per-channel beat valid; must not depend on req_ready
//  req_data      in   N_CH*DATA_WIDTH  channel c payload at [c*DATA_WIDTH +: DATA_WIDTH]
//  req_ready     out  N_CH             beat of channel c accepted this cycle when valid&ready
//  fifo_full     in   1                streaming_fifo full
//  fifo_wr_en    out  1                FIFO write strobe
//  fifo_wr_data  out  ID_W+DATA_WIDTH  {owner, req_data[owner]}
//  busy          out  1                1 while in BURST
//  owner         out  ID_W             current/last granted channel
// BEHAVIOUR
//  Reset values: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0, busy=0; req_ready=0, fifo_wr_en=0 follow.
//  FSM states:
//   IDLE:  no transfer; req_ready=0. If arb_en & |req_valid, owner <= first valid channel scanning
//          rr_ptr, rr_ptr+1, ... mod N_CH; beat_cnt<=0; -> BURST. Otherwise stay.
//          Arbitration costs one cycle; earliest first beat is the cycle after the grant.
//   BURST: req_ready[owner] = req_valid-independent = ~fifo_full; other bits 0.
//          xfer = req_valid[owner] & ~fifo_full (combinational, zero latency).
//          fifo_wr_en = xfer; fifo_wr_data = {owner, req_data[owner]}.
//          On xfer: beat_cnt++. If beat_cnt==BURST_LEN-1: -> IDLE, rr_ptr<=(owner+1)%N_CH.
//          If ~req_valid[owner] (no xfer): release -> IDLE, rr_ptr<=(owner+1)%N_CH.
//  Boundary conditions:
//   - fifo_full in BURST: hold; no write; beat_cnt frozen; owner kept (never released on full).
//   - arb_en drop mid-burst: burst continues to normal release; IDLE then grants nothing.
//   - Single valid channel: re-granted every other cycle (1 idle arbitration cycle between bursts).
//   - rr_ptr wraps N_CH-1 -> 0.
//   - BURST_LEN=1: every xfer releases.
//   - Valid on non-owner channels: ignored until that channel is granted; no data lost.
//   - rst mid-burst: immediate return to reset values; partial burst is abandoned and no FIFO write
//     occurs while rst is high.
//  Never writes when fifo_full=1; exactly one FIFO write per accepted beat.
// CONFIGURATION
//  SENSOR_ARB_STATS_EN defined:
//   - Adds outputs stall_cnt[15:0] and xfer_cnt[15:0], both reset 0 and saturating at 16'hFFFF.
//   - stall_cnt increments each BURST cycle with req_valid[owner] & fifo_full.
//   - xfer_cnt increments on each fifo_wr_en.
//  SENSOR_ARB_STATS_EN undefined: ports and counters are absent; functional behaviour is identical.
// TESTING
//  1 Ch1 only valid, data 11,22,33,44,55, BURST_LEN=4, fifo not full
//    -> writes {1,11},{1,22},{1,33},{1,44}; release; IDLE 1 cycle; regrant ch1; writes {1,55}.
//  2 All 4 ch continuously valid, data=ch*0x10+beat
//    -> owner order 0,1,2,3,0; 4 beats each; FIFO stream tags 0000 1111 2222 3333.
//  3 Ch2 bursting, fifo_full held 3 cycles after 2nd beat
//    -> no fifo_wr_en and req_ready[2]=0 during those cycles; beats 3-4 resume after; no duplicate/loss.
//  4 Ch3 valid drops after 2 beats while ch0 is valid
//    -> release after 2 writes; next grant ch0 (wrap from rr_ptr=0).
//  5 arb_en=0 at reset with all valid -> no writes; arb_en=1 -> grant ch0;
//    arb_en=0 mid-burst -> burst finishes 4 beats, then idle.
//  6 rst pulsed during beat 2 of a burst
//    -> outputs to reset values same cycle; after release first grant goes to ch0;
//    with SENSOR_ARB_STATS_EN: xfer_cnt=0, stall_cnt=0.

Source files
------------

// File: rtl/sensor_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// sensor_fifo_arbiter
//
// Round-robin burst arbiter that lets N_CH sensor channels share the single
// write port of a streaming FIFO. One channel owns the port at a time and may
// push up to BURST_LEN beats before ownership passes on. Every accepted beat
// is written to the FIFO tagged with the owning channel's id.
//
// Ports:
//   clk           in   clock, all logic on the rising edge
//   rst           in   asynchronous reset, active-high
//   arb_en        in   1 = new grants allowed; a running burst always completes
//   req_valid     in   per-channel beat valid (must not depend on req_ready)
//   req_data      in   channel c payload at [c*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     out  beat of channel c accepted when valid & ready
//   fifo_full     in   FIFO full
//   fifo_wr_en    out  FIFO write strobe
//   fifo_wr_data  out  {owner, req_data[owner]}
//   busy          out  1 while a burst is in progress
//   owner         out  current / last granted channel
//   stall_cnt     out  (SENSOR_ARB_STATS_EN only) burst cycles blocked by full
//   xfer_cnt      out  (SENSOR_ARB_STATS_EN only) FIFO writes performed
//
// Configuration macro: SENSOR_ARB_STATS_EN adds the two saturating 16-bit
// statistics counters. Without it the ports and counters do not exist and
// the arbitration behaviour is unchanged.
// -----------------------------------------------------------------------------
module sensor_fifo_arbiter #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_W       = 2,
    parameter int BURST_LEN  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arb_en,
    input  logic [N_CH-1:0]              req_valid,
    input  logic [N_CH*DATA_WIDTH-1:0]   req_data,
    output logic [N_CH-1:0]              req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [ID_W+DATA_WIDTH-1:0]   fifo_wr_data,
    output logic                         busy,
    output logic [ID_W-1:0]              owner
`ifdef SENSOR_ARB_STATS_EN
    ,
    output logic [15:0]                  stall_cnt,
    output logic [15:0]                  xfer_cnt
`endif
);

    localparam int              CNT_W     = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ID_W-1:0]       owner_next;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       rr_ptr_next;
    logic [ID_W-1:0]       grant_ch;
    logic [ID_W-1:0]       owner_inc;
    logic [CNT_W-1:0]      beat_cnt;
    logic [CNT_W-1:0]      beat_cnt_next;
    logic                  owner_valid;
    logic                  picked;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] owner_data;
    int                    scan_idx;

    // Valid bit and payload of whichever channel currently owns the port.
    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (owner == ID_W'(c)) begin
                owner_valid = req_valid[c];
                owner_data  = req_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin pick: first valid channel starting at rr_ptr, wrapping at N_CH.
    always_comb begin
        grant_ch = rr_ptr;
        picked   = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < N_CH; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= N_CH) begin
                scan_idx = scan_idx - N_CH;
            end
            if (!picked && req_valid[scan_idx]) begin
                grant_ch = ID_W'(scan_idx);
                picked   = 1'b1;
            end
        end
    end

    // Pointer for the next arbitration round once the current owner lets go.
    assign owner_inc = (owner == ID_W'(N_CH - 1)) ? '0 : owner + 1'b1;

    // A beat moves only when the owner offers one and the FIFO has room.
    assign xfer = (state == BURST) && owner_valid && !fifo_full;

    // Next-state logic. A full FIFO freezes the burst completely, even if the
    // owner's valid has dropped; release on an idle owner only happens when
    // the FIFO could have taken a beat.
    always_comb begin
        state_next    = state;
        owner_next    = owner;
        rr_ptr_next   = rr_ptr;
        beat_cnt_next = beat_cnt;
        case (state)
            IDLE: begin
                if (arb_en && (|req_valid)) begin
                    owner_next    = grant_ch;
                    beat_cnt_next = '0;
                    state_next    = BURST;
                end
            end
            BURST: begin
                if (!fifo_full) begin
                    if (owner_valid) begin
                        beat_cnt_next = beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state_next  = IDLE;
                            rr_ptr_next = owner_inc;
                        end
                    end else begin
                        state_next  = IDLE;
                        rr_ptr_next = owner_inc;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any partial burst immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            rr_ptr   <= rr_ptr_next;
            beat_cnt <= beat_cnt_next;
        end
    end

    // Ready is offered to the owner whenever the FIFO has room, regardless of
    // its valid, so the handshake has no combinational loop through valid.
    always_comb begin
        req_ready = '0;
        if ((state == BURST) && !fifo_full) begin
            for (int c = 0; c < N_CH; c++) begin
                req_ready[c] = (owner == ID_W'(c));
            end
        end
    end

    assign busy         = (state == BURST);
    assign fifo_wr_en   = xfer;
    assign fifo_wr_data = {owner, owner_data};

`ifdef SENSOR_ARB_STATS_EN
    // Saturating statistics: stalls are burst cycles with a waiting beat
    // blocked by a full FIFO; transfers count FIFO writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            xfer_cnt  <= '0;
        end else begin
            if ((state == BURST) && owner_valid && fifo_full && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (xfer && (xfer_cnt != 16'hFFFF)) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sensor_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sensor_fifo_arbiter
//
// Self-checking bench for sensor_fifo_arbiter. Two instances share the same
// stimulus: u_dut0 with BURST_LEN=4 and u_dut1 with BURST_LEN=1. A small
// behavioural model (one per instance) predicts busy/owner/ready/write
// outputs each cycle; a table of hand-derived vectors and a few directed
// sequences cover the corner cases before a randomized run.
// -----------------------------------------------------------------------------
module tb_sensor_fifo_arbiter;

    localparam int N_CH = 4;
    localparam int DW   = 8;
    localparam int ID_W = 2;
    localparam int W    = ID_W + DW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 arb_en;
    logic [N_CH-1:0]      req_valid;
    logic [N_CH*DW-1:0]   req_data;
    logic                 fifo_full;

    logic [N_CH-1:0]      ready0, ready1;
    logic                 wr0, wr1;
    logic [W-1:0]         data0, data1;
    logic                 busy0, busy1;
    logic [ID_W-1:0]      own0, own1;
`ifdef SENSOR_ARB_STATS_EN
    logic [15:0]          stall0, xfer0, stall1, xfer1;
`endif

    int checks   = 0;
    int failures = 0;

    // Clock generation
    always #5 clk = ~clk;

    sensor_fifo_arbiter #(.N_CH(N_CH), .DATA_WIDTH(DW), .ID_W(ID_W), .BURST_LEN(4)) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (ready0),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (wr0),
        .fifo_wr_data (data0),
        .busy         (busy0),
        .owner        (own0)
`ifdef SENSOR_ARB_STATS_EN
        ,
        .stall_cnt    (stall0),
        .xfer_cnt     (xfer0)
`endif
    );

    sensor_fifo_arbiter #(.N_CH(N_CH), .DATA_WIDTH(DW), .ID_W(ID_W), .BURST_LEN(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (ready1),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (wr1),
        .fifo_wr_data (data1),
        .busy         (busy1),
        .owner        (own1)
`ifdef SENSOR_ARB_STATS_EN
        ,
        .stall_cnt    (stall1),
        .xfer_cnt     (xfer1)
`endif
    );

    // Behavioural model state, index 0 = BURST_LEN 4, index 1 = BURST_LEN 1.
    bit m_busy  [2];
    int m_owner [2];
    int m_ptr   [2];
    int m_beats [2];
    int m_stall [2];
    int m_xfer  [2];

    function automatic int burstLenOf(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k]  = 1'b0;
            m_owner[k] = 0;
            m_ptr[k]   = 0;
            m_beats[k] = 0;
            m_stall[k] = 0;
            m_xfer[k]  = 0;
        end
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic modelAdvance();
        for (int k = 0; k < 2; k++) begin
            if (!m_busy[k]) begin
                if (arb_en && (req_valid != '0)) begin
                    for (int i = N_CH - 1; i >= 0; i--) begin
                        if (req_valid[(m_ptr[k] + i) % N_CH]) begin
                            m_owner[k] = (m_ptr[k] + i) % N_CH;
                        end
                    end
                    m_beats[k] = 0;
                    m_busy[k]  = 1'b1;
                end
            end else if (fifo_full) begin
                if (req_valid[m_owner[k]]) begin
                    m_stall[k]++;
                end
            end else if (req_valid[m_owner[k]]) begin
                m_xfer[k]++;
                m_beats[k]++;
                if (m_beats[k] == burstLenOf(k)) begin
                    m_busy[k] = 1'b0;
                    m_ptr[k]  = (m_owner[k] + 1) % N_CH;
                end
            end else begin
                m_busy[k] = 1'b0;
                m_ptr[k]  = (m_owner[k] + 1) % N_CH;
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic [N_CH-1:0] v, input logic f,
                                 input logic [N_CH*DW-1:0] d);
        arb_en    = a;
        req_valid = v;
        fifo_full = f;
        req_data  = d;
    endtask

    // Compare one instance against the model for the current cycle.
    task automatic checkOutput(input int k);
        logic [N_CH-1:0] er;
        logic            ew;
        logic [W-1:0]    ed;
        int              own;
        own = m_owner[k];
        er  = '0;
        if (m_busy[k] && !fifo_full) begin
            er[own] = 1'b1;
        end
        ew = m_busy[k] && !fifo_full && req_valid[own];
        ed = {ID_W'(own), req_data[own*DW +: DW]};
        if (k == 0) begin
            checkVal("dut0.busy", 32'(busy0), 32'(m_busy[k]));
            checkVal("dut0.owner", 32'(own0), 32'(own));
            checkVal("dut0.req_ready", 32'(ready0), 32'(er));
            checkVal("dut0.fifo_wr_en", 32'(wr0), 32'(ew));
            if (ew) checkVal("dut0.fifo_wr_data", 32'(data0), 32'(ed));
`ifdef SENSOR_ARB_STATS_EN
            checkVal("dut0.stall_cnt", 32'(stall0), 32'(m_stall[k]));
            checkVal("dut0.xfer_cnt", 32'(xfer0), 32'(m_xfer[k]));
`endif
        end else begin
            checkVal("dut1.busy", 32'(busy1), 32'(m_busy[k]));
            checkVal("dut1.owner", 32'(own1), 32'(own));
            checkVal("dut1.req_ready", 32'(ready1), 32'(er));
            checkVal("dut1.fifo_wr_en", 32'(wr1), 32'(ew));
            if (ew) checkVal("dut1.fifo_wr_data", 32'(data1), 32'(ed));
`ifdef SENSOR_ARB_STATS_EN
            checkVal("dut1.stall_cnt", 32'(stall1), 32'(m_stall[k]));
            checkVal("dut1.xfer_cnt", 32'(xfer1), 32'(m_xfer[k]));
`endif
        end
    endtask

    // Advance one clock; the model holds while reset is asserted.
    task automatic tick();
        if (!rst) modelAdvance();
        @(posedge clk);
        #1;
    endtask

    // One fully model-checked cycle for both instances.
    task automatic modelCycle(input logic a, input logic [N_CH-1:0] v, input logic f,
                              input logic [N_CH*DW-1:0] d);
        applyStimulus(a, v, f, d);
        #1;
        checkOutput(0);
        checkOutput(1);
        tick();
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        modelReset();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic            a;
        logic [N_CH-1:0] v;
        logic            f;
        logic [DW-1:0]   d;
        logic [N_CH-1:0] er;
        logic            ew;
        logic [W-1:0]    ed;
        logic            eb;
        logic [ID_W-1:0] eo;
    } vec_t;

    vec_t tbl[18];
    int   tags[$];
    int   wr_count;

    initial begin
        // Hand-derived vectors for u_dut0 (BURST_LEN 4) starting from reset;
        // the payload byte is broadcast to every channel.
        tbl[0]  = '{1'b1, 4'b0010, 1'b0, 8'h11, 4'b0000, 1'b0, 10'h000, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 4'b0010, 1'b0, 8'h11, 4'b0010, 1'b1, 10'h111, 1'b1, 2'd1};
        tbl[2]  = '{1'b1, 4'b0010, 1'b0, 8'h22, 4'b0010, 1'b1, 10'h122, 1'b1, 2'd1};
        tbl[3]  = '{1'b1, 4'b0010, 1'b0, 8'h33, 4'b0010, 1'b1, 10'h133, 1'b1, 2'd1};
        tbl[4]  = '{1'b1, 4'b0010, 1'b0, 8'h44, 4'b0010, 1'b1, 10'h144, 1'b1, 2'd1};
        tbl[5]  = '{1'b1, 4'b0010, 1'b0, 8'h55, 4'b0000, 1'b0, 10'h000, 1'b0, 2'd1};
        tbl[6]  = '{1'b1, 4'b0010, 1'b0, 8'h55, 4'b0010, 1'b1, 10'h155, 1'b1, 2'd1};
        tbl[7]  = '{1'b1, 4'b0000, 1'b0, 8'h00, 4'b0010, 1'b0, 10'h000, 1'b1, 2'd1};
        tbl[8]  = '{1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 10'h000, 1'b0, 2'd1};
        tbl[9]  = '{1'b1, 4'b0100, 1'b0, 8'hA1, 4'b0000, 1'b0, 10'h000, 1'b0, 2'd1};
        tbl[10] = '{1'b1, 4'b0100, 1'b0, 8'hA1, 4'b0100, 1'b1, 10'h2A1, 1'b1, 2'd2};
        tbl[11] = '{1'b1, 4'b0100, 1'b1, 8'hA2, 4'b0000, 1'b0, 10'h000, 1'b1, 2'd2};
        tbl[12] = '{1'b1, 4'b0100, 1'b1, 8'hA2, 4'b0000, 1'b0, 10'h000, 1'b1, 2'd2};
        tbl[13] = '{1'b1, 4'b0000, 1'b1, 8'hA2, 4'b0000, 1'b0, 10'h000, 1'b1, 2'd2};
        tbl[14] = '{1'b1, 4'b0100, 1'b0, 8'hA2, 4'b0100, 1'b1, 10'h2A2, 1'b1, 2'd2};
        tbl[15] = '{1'b1, 4'b0100, 1'b0, 8'hA3, 4'b0100, 1'b1, 10'h2A3, 1'b1, 2'd2};
        tbl[16] = '{1'b1, 4'b0100, 1'b0, 8'hA4, 4'b0100, 1'b1, 10'h2A4, 1'b1, 2'd2};
        tbl[17] = '{1'b1, 4'b0100, 1'b0, 8'hA4, 4'b0000, 1'b0, 10'h000, 1'b0, 2'd2};

        // Reset with everything requesting: outputs must stay at reset values.
        rst = 1'b1;
        modelReset();
        applyStimulus(1'b1, 4'b1111, 1'b0, 32'h44332211);
        @(posedge clk);
        #1;
        checkVal("reset.busy", 32'(busy0), 32'd0);
        checkVal("reset.owner", 32'(own0), 32'd0);
        checkVal("reset.req_ready", 32'(ready0), 32'd0);
        checkVal("reset.fifo_wr_en", 32'(wr0), 32'd0);
        checkOutput(1);
        tick();
        rst = 1'b0;

        // Table vectors: single-channel bursts, regrant gap, FIFO-full hold.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i].a, tbl[i].v, tbl[i].f, {N_CH{tbl[i].d}});
            #1;
            checkVal($sformatf("vec%0d.req_ready", i), 32'(ready0), 32'(tbl[i].er));
            checkVal($sformatf("vec%0d.fifo_wr_en", i), 32'(wr0), 32'(tbl[i].ew));
            if (tbl[i].ew) checkVal($sformatf("vec%0d.fifo_wr_data", i), 32'(data0), 32'(tbl[i].ed));
            checkVal($sformatf("vec%0d.busy", i), 32'(busy0), 32'(tbl[i].eb));
            checkVal($sformatf("vec%0d.owner", i), 32'(own0), 32'(tbl[i].eo));
            checkOutput(1);
            tick();
        end

        // Arbitration disabled with all channels valid: nothing may be granted.
        pulseReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b1111, 1'b0, 32'h30201000);
            #1;
            checkVal("arb_off.fifo_wr_en", 32'(wr0), 32'd0);
            checkOutput(0);
            checkOutput(1);
            tick();
        end

        // All channels continuously valid: tags 0000 1111 2222 3333.
        tags.delete();
        for (int b = 0; b < 21; b++) begin
            applyStimulus(1'b1, 4'b1111, 1'b0,
                          {8'(8'h30 + b), 8'(8'h20 + b), 8'(8'h10 + b), 8'(b)});
            #1;
            if (wr0) tags.push_back(int'(data0[W-1:DW]));
            checkOutput(0);
            checkOutput(1);
            tick();
        end
        checkVal("rr.tag_count", 32'(tags.size()), 32'd16);
        for (int i = 0; i < tags.size() && i < 16; i++) begin
            checkVal($sformatf("rr.tag%0d", i), 32'(tags[i]), 32'(i / 4));
        end

        // Drop arb_en after the first beat of ch0's burst: burst still ends at 4.
        wr_count = 0;
        for (int b = 0; b < 9; b++) begin
            applyStimulus((b == 0), 4'b1111, 1'b0, 32'hD4C3B2A1);
            #1;
            if (wr0) wr_count++;
            checkOutput(0);
            checkOutput(1);
            tick();
        end
        checkVal("arb_drop.writes", 32'(wr_count), 32'd4);
        checkVal("arb_drop.busy", 32'(busy0), 32'd0);

        // Reset during beat 2 of a burst: outputs drop at once, then ch0 wins.
        modelCycle(1'b1, 4'b1111, 1'b0, 32'h01020304);
        modelCycle(1'b1, 4'b1111, 1'b0, 32'h05060708);
        applyStimulus(1'b1, 4'b1111, 1'b0, 32'h090A0B0C);
        #1;
        checkVal("rst_mid.pre_wr_en", 32'(wr0), 32'd1);
        rst = 1'b1;
        #1;
        checkVal("rst_mid.fifo_wr_en", 32'(wr0), 32'd0);
        checkVal("rst_mid.busy", 32'(busy0), 32'd0);
        checkVal("rst_mid.owner", 32'(own0), 32'd0);
        checkVal("rst_mid.req_ready", 32'(ready0), 32'd0);
`ifdef SENSOR_ARB_STATS_EN
        checkVal("rst_mid.xfer_cnt", 32'(xfer0), 32'd0);
        checkVal("rst_mid.stall_cnt", 32'(stall0), 32'd0);
`endif
        modelReset();
        tick();
        rst = 1'b0;
        modelCycle(1'b1, 4'b1111, 1'b0, 32'h11111111);
        checkVal("rst_mid.regrant_owner", 32'(own0), 32'd0);
        checkVal("rst_mid.regrant_busy", 32'(busy0), 32'd1);

        // Ch3 drops valid after 2 beats while ch0 waits: pointer wraps to ch0.
        pulseReset();
        modelCycle(1'b1, 4'b1000, 1'b0, 32'h33000000);
        modelCycle(1'b1, 4'b1000, 1'b0, 32'h34000000);
        modelCycle(1'b1, 4'b1000, 1'b0, 32'h35000000);
        modelCycle(1'b1, 4'b0001, 1'b0, 32'h000000C0);
        modelCycle(1'b1, 4'b0001, 1'b0, 32'h000000C1);
        checkVal("wrap.owner", 32'(own0), 32'd0);
        checkVal("wrap.busy", 32'(busy0), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            modelCycle(($urandom_range(0, 9) != 0), N_CH'($urandom),
                       ($urandom_range(0, 4) == 0), ($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
